uart_rx_byte: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_sync_filter.sv | 35 +++
 rtl/uart_rx_byte.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and data width.
// Used by uart_rx_byte and intended for reuse by a future uart_tx_byte.
package uart_pkg;

  // Default bit period: 10 MHz core clock, 115200 baud.
  localparam int unsigned UART_CLKS_PER_BIT = 87;

  // Payload width of one UART frame.
  localparam int unsigned UART_DATA_W = 8;

  // Receiver/transmitter frame states. PARITY is only reachable when the
  // parity option is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/rx_sync_filter.sv
// Input conditioning for the UART receiver: two-flop synchronizer on the
// asynchronous rx line followed by a 3-tap majority vote to reject
// single-sample noise. All flops preset to 1 (idle line) on reset and hold
// while ce is low.
module rx_sync_filter (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic rx,
  output logic rxf
);

  logic       sync1;
  logic       sync2;
  logic [2:0] taps;

  // Synchronize rx into the clock domain and shift synced samples into the vote window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      taps  <= '1;
    end else if (ce) begin
      sync1 <= rx;
      sync2 <= sync1;
      taps  <= {taps[1:0], sync2};
    end
  end

  // Majority of the three most recent synced samples.
  always_comb begin
    rxf = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, LSB first) feeding the boot loader.
// Produces one-cycle data_valid / frame_err strobes, qualified by ce.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   data_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e            state,    state_n;
  logic [CNT_W-1:0]       bit_cnt,  bit_cnt_n;
  logic [2:0]             idx,      idx_n;
  logic [UART_DATA_W-1:0] shreg,    shreg_n;
  logic [UART_DATA_W-1:0] data_q,   data_n;
  logic                   dv_q,     dv_n;
  logic                   fe_q,     fe_n;
  logic                   rxf_prev;
  logic                   rxf;
  logic                   mid;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q,   perr_n;
`endif

  rx_sync_filter u_filter (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .rx  (rx),
    .rxf (rxf)
  );

  // State and datapath registers; everything holds while ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      idx      <= '0;
      shreg    <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      rxf_prev <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else if (ce) begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      data_q   <= data_n;
      dv_q     <= dv_n;
      fe_q     <= fe_n;
      rxf_prev <= rxf;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_n;
`endif
    end
  end

  // Next-state, bit timing, shift register and strobe generation.
  // bit_cnt free-runs through START into DATA/PARITY/STOP so every mid-bit
  // sample lands one full bit period after the previous one.
  always_comb begin
    state_n   = state;
    bit_cnt_n = (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
    idx_n     = idx;
    shreg_n   = shreg;
    data_n    = data_q;
    dv_n      = 1'b0;
    fe_n      = 1'b0;
    mid       = (bit_cnt == MID_CNT);
`ifdef UART_RX_PARITY_EN
    perr_n    = perr_q;
`endif

    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        idx_n     = '0;
`ifdef UART_RX_PARITY_EN
        perr_n    = 1'b0;
`endif
        if (rxf_prev && !rxf) begin
          state_n = START;
        end
      end

      START: begin
        if (mid) begin
          if (rxf) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
      end

      DATA: begin
        if (mid) begin
          shreg_n = {rxf, shreg[UART_DATA_W-1:1]};
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) begin
          perr_n  = ^{shreg, rxf};
          state_n = STOP;
        end
      end
`endif

      STOP: begin
        if (mid) begin
          if (rxf) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (perr_q) begin
              fe_n = 1'b1;
            end else begin
              data_n = shreg;
              dv_n   = 1'b1;
            end
`else
            data_n = shreg;
            dv_n   = 1'b1;
`endif
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        bit_cnt_n = '0;
        if (rxf) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Strobes are suppressed while ce is low and released on the next ce-active cycle.
  always_comb begin
    data_out   = data_q;
    data_valid = dv_q & ce;
    frame_err  = fe_q & ce;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte with CLKS_PER_BIT = 16.
// Table of frames with expected strobes/data, plus hand sequences for
// reset, false start, back-to-back frames, reset mid-frame and ce gating.
module tb_uart_rx_byte;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         vec_cnt   = 0;
  int         mis_cnt   = 0;
  int         dv_cnt    = 0;
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  int         busy_cnt  = 0;
  logic [7:0] got_q[$];
  bit         ce_toggle = 1'b0;
  int         bit_clks  = CPB;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      got_q.push_back(data_out);
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
    if (busy) busy_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_bad;
    int         tail_low;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ce_toggle) ce = ~ce;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(bit_clks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                            input int tail_low);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_bad);
`endif
    send_bit(stop);
    if (tail_low > 0) begin
      rx = 1'b0;
      tick(tail_low * bit_clks);
    end
    rx = 1'b1;
  endtask

  initial begin
    int dv0, fe0, b0, n0;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0, 1, 0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 3, 0, 1, 8'hA5});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 0, 1, 0, 8'h81});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0, 1, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0, 1, 0, 8'hFF});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 1, 8'hFF});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 1, 0, 8'h07});
`endif

    // Reset state.
    rst = 1'b1;
    ce  = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset data_out", data_out, 8'h00);
    check("reset data_valid", data_valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    tick(CPB);

    // Table-driven frames.
    for (int i = 0; i < vecs.size(); i++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_bad, vecs[i].tail_low);
      tick(2 * bit_clks);
      check($sformatf("vec%0d data_valid count", i), dv_cnt - dv0, vecs[i].exp_dv);
      check($sformatf("vec%0d frame_err count", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_out);
      check($sformatf("vec%0d busy idle", i), busy, 1'b0);
    end

    // Short low glitch: false start, no strobes.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    b0  = busy_cnt;
    rx  = 1'b0;
    tick(6);
    rx  = 1'b1;
    tick(CPB);
    check("glitch busy seen", (busy_cnt > b0) ? 1 : 0, 1);
    check("glitch busy cleared", busy, 1'b0);
    check("glitch data_valid count", dv_cnt - dv0, 0);
    check("glitch frame_err count", fe_cnt - fe0, 0);
    tick(CPB);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt;
    n0  = got_q.size();
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    send_frame(8'h55, 1'b1, 1'b0, 0);
    tick(2 * CPB);
    check("b2b data_valid count", dv_cnt - dv0, 3);
    check("b2b byte0", (got_q.size() > n0)     ? got_q[n0]     : 8'hxx, 8'h00);
    check("b2b byte1", (got_q.size() > n0 + 1) ? got_q[n0 + 1] : 8'hxx, 8'hFF);
    check("b2b byte2", (got_q.size() > n0 + 2) ? got_q[n0 + 2] : 8'hxx, 8'h55);

    // Reset (with ce low) in the middle of a data phase.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("abort busy mid frame", busy, 1'b1);
    ce  = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    ce  = 1'b1;
    rx  = 1'b1;
    tick(1);
    check("abort data_out zero", data_out, 8'h00);
    check("abort busy cleared", busy, 1'b0);
    tick(12 * CPB);
    check("abort no data_valid", dv_cnt - dv0, 0);
    check("abort no frame_err", fe_cnt - fe0, 0);
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    tick(2 * CPB);
    check("after abort data_valid count", dv_cnt - dv0, 1);
    check("after abort data_out", data_out, 8'h7E);

    // ce toggling every cycle, bit time doubled to 32 clocks.
    dv0       = dv_cnt;
    fe0       = fe_cnt;
    bit_clks  = 2 * CPB;
    ce_toggle = 1'b1;
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    tick(2 * bit_clks);
    ce_toggle = 1'b0;
    ce        = 1'b1;
    bit_clks  = CPB;
    tick(1);
    check("ce gated data_valid count", dv_cnt - dv0, 1);
    check("ce gated frame_err count", fe_cnt - fe0, 0);
    check("ce gated data_out", data_out, 8'hC3);
    check("ce gated busy idle", busy, 1'b0);

    check("strobes never overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
